// File: rtl/axi_burst_read_master.sv
// axi_burst_read_master: single-outstanding AXI4 INCR burst reader with a one-entry registered output stream
module axi_burst_read_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_SIZE      = $clog2(STROBE_WIDTH)
) (
    input  logic                     i_aclk,
    input  logic                     i_areset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_addr,
    input  logic [7:0]               i_cmd_len,
    input  logic [2:0]               i_cmd_size,
    output logic [ADDRESS_WIDTH-1:0] o_araddr,
    output logic [7:0]               o_arlen,
    output logic [2:0]               o_arsize,
    output logic [1:0]               o_arburst,
    output logic                     o_arvalid,
    input  logic                     i_arready,
    input  logic [DATA_WIDTH-1:0]    i_rdata,
    input  logic [1:0]               i_rresp,
    input  logic                     i_rlast,
    input  logic                     i_rvalid,
    output logic                     o_rready,
    output logic [DATA_WIDTH-1:0]    o_out_data,
    output logic                     o_out_last,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_done,
    output logic                     o_err
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_ERR, S_DONE} state_t;
    state_t                   r_state;
    logic [8:0]               r_beats_left;
    logic                     r_cmd_ready;
    logic [ADDRESS_WIDTH-1:0] r_araddr;
    logic [7:0]               r_arlen;
    logic [2:0]               r_arsize;
    logic                     r_arvalid;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic                     r_out_last;
    logic                     r_out_valid;
    logic                     r_done;
    logic                     r_err;
    logic                     w_rready;
    logic                     w_r_hs;
    logic                     w_out_hs;
    logic                     w_last_beat;
    logic                     w_size_ok;
    // R is accepted whenever the single buffer slot is free or being freed this cycle
    assign w_rready    = (r_state == S_DATA) && (!r_out_valid || i_out_ready);
    assign w_r_hs      = i_rvalid && w_rready;
    assign w_out_hs    = r_out_valid && i_out_ready;
    assign w_last_beat = (r_beats_left == 9'd1);
    assign w_size_ok   = (i_cmd_size <= 3'(MAX_SIZE));
    assign o_cmd_ready = r_cmd_ready;
    assign o_araddr    = r_araddr;
    assign o_arlen     = r_arlen;
    assign o_arsize    = r_arsize;
    assign o_arburst   = 2'b01;
    assign o_arvalid   = r_arvalid;
    assign o_rready    = w_rready;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_out_valid = r_out_valid;
    assign o_done      = r_done;
    assign o_err       = r_err;
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state      <= S_IDLE;
            r_beats_left <= '0;
            r_cmd_ready  <= 1'b1;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_arvalid    <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_r_hs) begin
                r_out_data  <= i_rdata;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_beat;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: if (i_cmd_valid) begin
                    r_cmd_ready  <= 1'b0;
                    r_araddr     <= i_cmd_addr;
                    r_arlen      <= i_cmd_len;
                    r_arsize     <= i_cmd_size;
                    r_beats_left <= {1'b0, i_cmd_len} + 9'd1;
                    r_err        <= 1'b0;
                    r_arvalid    <= w_size_ok;
                    r_state      <= w_size_ok ? S_ADDR : S_ERR;
                end
                S_ADDR: if (i_arready) begin
                    r_arvalid <= 1'b0;
                    r_state   <= S_DATA;
                end
                // an early or missing rlast is flagged but the beat count alone ends the burst
                S_DATA: if (w_r_hs) begin
                    r_beats_left <= r_beats_left - 9'd1;
                    if (i_rresp != 2'b00 || i_rlast != w_last_beat) r_err <= 1'b1;
                    if (w_last_beat) r_state <= S_DRAIN;
                end
                S_DRAIN: if (!r_out_valid || i_out_ready) begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_ERR: begin
                    r_err   <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_read_master.sv
// tb_axi_burst_read_master: table-driven and randomized bursts against a byte-addressed RAM model
module tb_axi_burst_read_master;
    logic        i_aclk = 1'b0;
    logic        i_areset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [7:0]  i_cmd_addr = '0;
    logic [7:0]  i_cmd_len = '0;
    logic [2:0]  i_cmd_size = '0;
    logic [7:0]  o_araddr;
    logic [7:0]  o_arlen;
    logic [2:0]  o_arsize;
    logic [1:0]  o_arburst;
    logic        o_arvalid;
    logic        i_arready = 1'b0;
    logic [31:0] i_rdata = '0;
    logic [1:0]  i_rresp = '0;
    logic        i_rlast = 1'b0;
    logic        i_rvalid = 1'b0;
    logic        o_rready;
    logic [31:0] o_out_data;
    logic        o_out_last;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic        o_done;
    logic        o_err;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  len;
        logic [2:0]  size;
        int          rmode;
        int          err_beat;
        int          flip_beat;
        int          abort;
        int          exp_beats;
        logic        exp_err;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    axi_burst_read_master dut (
        .i_aclk(i_aclk), .i_areset(i_areset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .i_cmd_size(i_cmd_size),
        .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
        .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_out_data(o_out_data), .o_out_last(o_out_last), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_aclk = ~i_aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM holds byte value (address mod 256); each beat carries only its active byte lanes
    function automatic logic [31:0] beat_word(int addr, int size, int k);
        int n = 1 << size;
        int al = addr - (addr % n);
        int st = (k == 0) ? addr : al + k * n;
        int en = (st - (st % n)) + n;
        logic [31:0] w = '0;
        for (int b = st; b < en; b++) w[(b % 4) * 8 +: 8] = 8'(b % 256);
        return w;
    endfunction

    task automatic run_cmd(input vec_t v, output int nbeats, output logic [31:0] first_w,
                           output logic [31:0] last_w, output logic errv);
        logic [31:0] expq[$];
        logic [31:0] prev_rdata;
        logic [31:0] exp_w;
        logic legal, exp_err, ar_seen, ar_hs, r_hs, out_hs, prev_r_hs, finished;
        int len, k, rcnt, last_out_c;
        len = int'(v.len);
        legal = (v.size <= 3'd2);
        exp_err = !legal || (v.err_beat >= 0 && v.err_beat <= len) || (v.flip_beat >= 0 && v.flip_beat <= len);
        if (legal) for (int i = 0; i <= len; i++) expq.push_back(beat_word(int'(v.addr), int'(v.size), i));
        nbeats = 0; first_w = '0; last_w = '0; errv = 1'b0;
        ar_seen = 1'b0; k = 0; rcnt = 0; last_out_c = -1; prev_r_hs = 1'b0; prev_rdata = '0; finished = 1'b0;
        i_cmd_addr = v.addr; i_cmd_len = v.len; i_cmd_size = v.size; i_cmd_valid = 1'b1;
        @(negedge i_aclk);
        chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
        @(posedge i_aclk); #1;
        i_cmd_valid = 1'b0; i_rvalid = 1'b0; i_out_ready = 1'b1;
        i_arready = 1'($urandom_range(0, 1));
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(negedge i_aclk);
            if (c == 0) chk("ar_latency", 32'(o_arvalid), 32'(legal));
            if (!legal) chk("no_ar_illegal", 32'(o_arvalid), 32'd0);
            if (prev_r_hs) begin
                chk("out_latency", 32'(o_out_valid), 32'd1);
                chk("out_latency_data", o_out_data, prev_rdata);
            end
            ar_hs = o_arvalid && i_arready;
            r_hs = i_rvalid && o_rready;
            out_hs = o_out_valid && i_out_ready;
            if (ar_hs) begin
                chk("araddr", 32'(o_araddr), 32'(v.addr));
                chk("arlen", 32'(o_arlen), 32'(v.len));
                chk("arsize", 32'(o_arsize), 32'(v.size));
                chk("arburst", 32'(o_arburst), 32'd1);
            end
            if (o_out_valid && !i_out_ready) chk("rready_backpressure", 32'(o_rready), 32'd0);
            if (out_hs) begin
                exp_w = (expq.size() > 0) ? expq.pop_front() : ~o_out_data;
                chk("beat_data", o_out_data, exp_w);
                chk("beat_last", 32'(o_out_last), 32'(expq.size() == 0));
                if (nbeats == 0) first_w = o_out_data;
                last_w = o_out_data;
                nbeats++;
                last_out_c = c;
            end
            if (o_done) begin
                chk("done_latency", 32'(c), 32'(legal ? last_out_c + 1 : 1));
                chk("err_at_done", 32'(o_err), 32'(exp_err));
                chk("beats_outstanding", 32'(expq.size()), 32'd0);
                errv = o_err;
                @(posedge i_aclk); #1;
                @(negedge i_aclk);
                chk("done_pulse", 32'(o_done), 32'd0);
                chk("err_hold", 32'(o_err), 32'(exp_err));
                chk("cmd_ready_after", 32'(o_cmd_ready), 32'd1);
                @(posedge i_aclk); #1;
                finished = 1'b1;
            end else begin
                chk("cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
                prev_rdata = i_rdata;
                prev_r_hs = r_hs;
                @(posedge i_aclk); #1;
                if (ar_hs) ar_seen = 1'b1;
                if (r_hs) begin k++; rcnt++; end
                if (v.abort >= 0 && rcnt == v.abort) begin
                    i_areset = 1'b1; i_rvalid = 1'b0;
                    @(posedge i_aclk); #1;
                    i_areset = 1'b0;
                    @(negedge i_aclk);
                    chk("abort_arvalid", 32'(o_arvalid), 32'd0);
                    chk("abort_rready", 32'(o_rready), 32'd0);
                    chk("abort_out_valid", 32'(o_out_valid), 32'd0);
                    chk("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
                    chk("abort_done", 32'(o_done), 32'd0);
                    @(posedge i_aclk); #1;
                    finished = 1'b1;
                end else begin
                    if (!(i_rvalid && !r_hs)) begin
                        i_rvalid = ar_seen && k <= len && ($urandom_range(0, 3) != 0);
                        i_rdata = beat_word(int'(v.addr), int'(v.size), k);
                        i_rresp = (k == v.err_beat) ? 2'b10 : 2'b00;
                        i_rlast = (k == len) ^ (k == v.flip_beat);
                    end
                    i_arready = 1'($urandom_range(0, 1));
                    i_out_ready = (v.rmode == 0) ? 1'b1 : (v.rmode == 1) ? !i_out_ready : 1'($urandom_range(0, 1));
                end
            end
        end
        chk("finished_in_budget", 32'(finished), 32'd1);
        i_rvalid = 1'b0;
    endtask

    initial begin
        vec_t tbl[11];
        vec_t v;
        int nb;
        logic [31:0] fw, lw;
        logic ev;
        repeat (2) @(posedge i_aclk);
        @(negedge i_aclk);
        chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_arvalid", 32'(o_arvalid), 32'd0);
        chk("rst_rready", 32'(o_rready), 32'd0);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_out_data", o_out_data, 32'd0);
        chk("rst_araddr", 32'(o_araddr), 32'd0);
        @(posedge i_aclk); #1;
        i_areset = 1'b0;
        tbl[0]  = '{8'h10, 8'd3,   3'd2, 0, -1, -1, -1, 4,   1'b0, 32'h13121110, 32'h1F1E1D1C};
        tbl[1]  = '{8'h10, 8'd3,   3'd2, 1, -1, -1, -1, 4,   1'b0, 32'h13121110, 32'h1F1E1D1C};
        tbl[2]  = '{8'h05, 8'd0,   3'd0, 0, -1, -1, -1, 1,   1'b0, 32'h00000500, 32'h00000500};
        tbl[3]  = '{8'h00, 8'd0,   3'd3, 0, -1, -1, -1, 0,   1'b1, 32'h0,        32'h0};
        tbl[4]  = '{8'h10, 8'd3,   3'd2, 0,  1, -1, -1, 4,   1'b1, 32'h13121110, 32'h1F1E1D1C};
        tbl[5]  = '{8'h10, 8'd3,   3'd2, 2, -1,  2, -1, 4,   1'b1, 32'h13121110, 32'h1F1E1D1C};
        tbl[6]  = '{8'h20, 8'd7,   3'd2, 0, -1, -1,  2, -1,  1'b0, 32'h0,        32'h0};
        tbl[7]  = '{8'h40, 8'd1,   3'd2, 0, -1, -1, -1, 2,   1'b0, 32'h43424140, 32'h47464544};
        tbl[8]  = '{8'h31, 8'd2,   3'd1, 2, -1, -1, -1, 3,   1'b0, 32'h00003100, 32'h00003534};
        tbl[9]  = '{8'hFC, 8'd1,   3'd2, 1, -1, -1, -1, 2,   1'b0, 32'hFFFEFDFC, 32'h03020100};
        tbl[10] = '{8'h00, 8'd255, 3'd2, 2, -1, -1, -1, 256, 1'b0, 32'h03020100, 32'hFFFEFDFC};
        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i], nb, fw, lw, ev);
            if (tbl[i].exp_beats >= 0) begin
                chk("tbl_beats", 32'(nb), 32'(tbl[i].exp_beats));
                chk("tbl_err", 32'(ev), 32'(tbl[i].exp_err));
                if (tbl[i].exp_beats > 0) begin
                    chk("tbl_first", fw, tbl[i].exp_first);
                    chk("tbl_last", lw, tbl[i].exp_last);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            v.addr = 8'($urandom);
            v.len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 40)) : 8'($urandom_range(0, 9));
            v.size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            v.rmode = int'($urandom_range(0, 2));
            v.err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(v.len))) : -1;
            v.flip_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(v.len))) : -1;
            v.abort = -1;
            v.exp_beats = (v.size <= 3'd2) ? int'(v.len) + 1 : 0;
            v.exp_err = (v.size > 3'd2) || v.err_beat >= 0 || v.flip_beat >= 0;
            run_cmd(v, nb, fw, lw, ev);
            chk("rnd_beats", 32'(nb), 32'(v.exp_beats));
            chk("rnd_err", 32'(ev), 32'(v.exp_err));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
